des_key_scheduler: RTL and testbench

DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

---
 rtl/des_key_scheduler.sv | 142 ++++++++++++++
 tb/tb_des_key_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_scheduler.sv
// DES key schedule: PC-1 on key accept, then one PC-2 subkey per handshake (K1..K16 or K16..K1).
// First subkey the cycle after accept; a subkey is held while i_subkey_ready=0; keys are taken only in IDLE.
module des_key_scheduler #(
    parameter bit CHECK_PARITY = 1'b1,
    parameter bit PARITY_ODD   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_valid,
    output logic        o_key_ready,
    input  logic [63:0] i_key,
    input  logic        i_decrypt,
    output logic        o_subkey_valid,
    input  logic        i_subkey_ready,
    output logic [47:0] o_subkey,
    output logic [3:0]  o_round,
    output logic        o_last,
    output logic        o_parity_err,
    input  logic        i_flush
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Table entries use FIPS numbering: bit 1 is the MSB of the vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_round;
    logic        r_dec;
    logic        r_perr;

    logic [55:0] w_pc1;
    logic [27:0] w_c0;
    logic [27:0] w_d0;
    logic        w_accept;
    logic        w_hs;
    logic        w_advance;
    logic [3:0]  w_shift_idx;
    logic        w_one;
    logic [7:0]  w_byte_bad;
    logic        w_perr;

    assign o_key_ready    = (r_state == IDLE);
    assign o_subkey_valid = (r_state == RUN);
    assign o_subkey       = pc2({r_c, r_d});
    assign o_round        = r_round;
    assign o_last         = ((r_round == 4'd15) & ~r_dec) | ((r_round == 4'd0) & r_dec);
    assign o_parity_err   = CHECK_PARITY ? r_perr : 1'b0;

    assign w_accept  = i_key_valid & o_key_ready;
    assign w_hs      = o_subkey_valid & i_subkey_ready;
    assign w_advance = w_hs & ~o_last & ~i_flush;

    assign w_pc1 = pc1(i_key);
    assign w_c0  = w_pc1[55:28];
    assign w_d0  = w_pc1[27:0];

    // Single-bit rotations belong to rounds 1, 2, 9, 16 (counter values 0, 1, 8, 15).
    // Encrypt moves into round counter+2; decrypt undoes round counter+1.
    assign w_shift_idx = r_dec ? r_round : r_round + 4'd1;
    assign w_one = (w_shift_idx == 4'd0) | (w_shift_idx == 4'd1) |
                   (w_shift_idx == 4'd8) | (w_shift_idx == 4'd15);

    genvar g;
    for (g = 0; g < 8; g++) begin : g_par
        assign w_byte_bad[g] = (^i_key[8*g +: 8]) != PARITY_ODD;
    end
    assign w_perr = CHECK_PARITY ? |w_byte_bad : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_key_valid) w_state_nxt = RUN;
            RUN:     if (i_flush || (w_hs && o_last)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_dec   <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_accept) begin
            r_c     <= i_decrypt ? w_c0 : rotl28(w_c0, 1'b1);
            r_d     <= i_decrypt ? w_d0 : rotl28(w_d0, 1'b1);
            r_round <= i_decrypt ? 4'd15 : 4'd0;
            r_dec   <= i_decrypt;
            r_perr  <= w_perr;
        end else if (w_advance) begin
            r_c     <= r_dec ? rotr28(r_c, w_one) : rotl28(r_c, w_one);
            r_d     <= r_dec ? rotr28(r_d, w_one) : rotl28(r_d, w_one);
            r_round <= r_dec ? r_round - 4'd1 : r_round + 4'd1;
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed + randomized bench for des_key_scheduler against a cumulative-rotation DES key schedule model.
// Checks run at #1 after each rising edge; the DUT's ready/valid behaviour is observed directly.
// Stalls are driven randomly on i_subkey_ready; no FIFO or credit state in the bench.
module tb_des_key_scheduler;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_key_valid;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        i_subkey_ready;
    logic        i_flush;

    logic        o_key_ready, o_subkey_valid, o_last, o_parity_err;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;

    logic        np_key_ready, np_subkey_valid, np_last, np_parity_err;
    logic [47:0] np_subkey;
    logic [3:0]  np_round;

    logic        ev_key_ready, ev_subkey_valid, ev_last, ev_parity_err;
    logic [47:0] ev_subkey;
    logic [3:0]  ev_round;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_k [16];
    logic        exp_pe;
    logic        exp_pe_ev;
    logic [47:0] last_sk;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    des_key_scheduler dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .o_key_ready(o_key_ready),
        .i_key(i_key), .i_decrypt(i_decrypt), .o_subkey_valid(o_subkey_valid),
        .i_subkey_ready(i_subkey_ready), .o_subkey(o_subkey), .o_round(o_round),
        .o_last(o_last), .o_parity_err(o_parity_err), .i_flush(i_flush));

    des_key_scheduler #(.CHECK_PARITY(1'b0)) dut_np (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .o_key_ready(np_key_ready),
        .i_key(i_key), .i_decrypt(i_decrypt), .o_subkey_valid(np_subkey_valid),
        .i_subkey_ready(i_subkey_ready), .o_subkey(np_subkey), .o_round(np_round),
        .o_last(np_last), .o_parity_err(np_parity_err), .i_flush(i_flush));

    des_key_scheduler #(.PARITY_ODD(1'b0)) dut_ev (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .o_key_ready(ev_key_ready),
        .i_key(i_key), .i_decrypt(i_decrypt), .o_subkey_valid(ev_subkey_valid),
        .i_subkey_ready(i_subkey_ready), .o_subkey(ev_subkey), .o_round(ev_round),
        .o_last(ev_last), .o_parity_err(ev_parity_err), .i_flush(i_flush));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: Ck/Dk are C0/D0 rotated left by the running total of shifts, then PC-2.
    task automatic model(input logic [63:0] key);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd;
        int cum, sh, ones, bad_odd, bad_even;
        for (int i = 0; i < 28; i++) begin
            c0[27 - i] = key[64 - M_PC1[i]];
            d0[27 - i] = key[64 - M_PC1[28 + i]];
        end
        cum = 0;
        for (int k = 1; k <= 16; k++) begin
            cum += (k == 1 || k == 2 || k == 9 || k == 16) ? 1 : 2;
            sh = cum % 28;
            c = (c0 << sh) | (c0 >> (28 - sh));
            d = (d0 << sh) | (d0 >> (28 - sh));
            cd = {c, d};
            for (int j = 0; j < 48; j++) exp_k[k - 1][47 - j] = cd[56 - M_PC2[j]];
        end
        bad_odd = 0;
        bad_even = 0;
        for (int b = 0; b < 8; b++) begin
            ones = $countones(key[8*b +: 8]);
            if (ones % 2 == 0) bad_odd = 1;
            else bad_even = 1;
        end
        exp_pe    = (bad_odd != 0);
        exp_pe_ev = (bad_even != 0);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] key, input logic dec);
        model(key);
        i_key = key;
        i_decrypt = dec;
        i_key_valid = 1'b1;
        step();
        i_key_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic drain(input logic dec, input logic rnd);
        int idx, hs, cyc;
        logic [47:0] held_sk;
        logic [3:0]  held_rd;
        logic        stalled;
        idx = dec ? 15 : 0;
        hs = 0;
        cyc = 0;
        stalled = 1'b0;
        held_sk = '0;
        held_rd = '0;
        while (hs < 16 && cyc < 400) begin
            i_subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) begin
                i_key_valid = ($urandom_range(0, 3) == 0);
                i_key = {$urandom, $urandom};
                i_decrypt = 1'($urandom);
            end
            chk("subkey_valid", o_subkey_valid, 1'b1);
            chk("key_ready_run", o_key_ready, 1'b0);
            chk("round", o_round, idx[3:0]);
            chk("subkey", o_subkey, exp_k[idx]);
            chk("last", o_last, (hs == 15));
            chk("parity_err", o_parity_err, exp_pe);
            chk("parity_err_nocheck", np_parity_err, 1'b0);
            chk("parity_err_even", ev_parity_err, exp_pe_ev);
            if (stalled) begin
                chk("stall_subkey", o_subkey, held_sk);
                chk("stall_round", o_round, held_rd);
            end
            held_sk = o_subkey;
            held_rd = o_round;
            stalled = !i_subkey_ready;
            if (i_subkey_ready) begin
                hs++;
                last_sk = o_subkey;
                idx = dec ? idx - 1 : idx + 1;
            end
            step();
            cyc++;
        end
        i_key_valid = 1'b0;
        i_subkey_ready = 1'b1;
        chk("handshakes", hs, 16);
        chk("key_ready_after", o_key_ready, 1'b1);
        chk("valid_after", o_subkey_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] rk;
        logic        rd;
        i_rst_n = 1'b0;
        i_key_valid = 1'b0;
        i_key = '0;
        i_decrypt = 1'b0;
        i_subkey_ready = 1'b1;
        i_flush = 1'b0;
        last_sk = '0;
        #13;
        chk("rst_key_ready", o_key_ready, 1'b1);
        chk("rst_valid", o_subkey_valid, 1'b0);
        chk("rst_subkey", o_subkey, 48'h0);
        chk("rst_round", o_round, 4'h0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_parity", o_parity_err, 1'b0);
        i_rst_n = 1'b1;
        step();
        chk("idle_key_ready", o_key_ready, 1'b1);

        // Known-answer encrypt schedule
        accept(KEY_STD, 1'b0);
        chk("enc_k1", o_subkey, K1_STD);
        chk("enc_parity", o_parity_err, 1'b0);
        drain(1'b0, 1'b0);
        chk("enc_k16", last_sk, K16_STD);

        // Known-answer decrypt schedule
        accept(KEY_STD, 1'b1);
        chk("dec_first", o_subkey, K16_STD);
        chk("dec_first_round", o_round, 4'd15);
        drain(1'b1, 1'b0);
        chk("dec_last", last_sk, K1_STD);

        // Bad parity byte: flag set, subkeys unchanged
        accept(KEY_BAD, 1'b0);
        chk("bad_parity_err", o_parity_err, 1'b1);
        chk("bad_parity_nocheck", np_parity_err, 1'b0);
        chk("bad_parity_k1", o_subkey, K1_STD);
        drain(1'b0, 1'b0);
        chk("bad_parity_k16", last_sk, K16_STD);

        // Random keys, random stalls, ignored key pulses during RUN
        for (int n = 0; n < 6; n++) begin
            rk = {$urandom, $urandom};
            rd = 1'($urandom);
            accept(rk, rd);
            drain(rd, 1'b1);
        end

        // Flush beats a handshake at round 5
        accept({$urandom, $urandom}, 1'b0);
        for (int r = 0; r < 5; r++) step();
        chk("flush_round", o_round, 4'd5);
        i_flush = 1'b1;
        i_subkey_ready = 1'b1;
        step();
        i_flush = 1'b0;
        chk("flush_valid", o_subkey_valid, 1'b0);
        chk("flush_key_ready", o_key_ready, 1'b1);
        // Flush in IDLE with a key offered: key still accepted
        i_flush = 1'b1;
        accept({$urandom, $urandom}, 1'b0);
        chk("restart_valid", o_subkey_valid, 1'b1);
        chk("restart_round", o_round, 4'd0);
        drain(1'b0, 1'b0);

        // Asynchronous reset at round 8
        accept(KEY_BAD, 1'b0);
        for (int r = 0; r < 8; r++) step();
        chk("pre_rst_round", o_round, 4'd8);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_key_ready", o_key_ready, 1'b1);
        chk("arst_valid", o_subkey_valid, 1'b0);
        chk("arst_subkey", o_subkey, 48'h0);
        chk("arst_round", o_round, 4'h0);
        chk("arst_last", o_last, 1'b0);
        chk("arst_parity", o_parity_err, 1'b0);
        chk("arst_parity_even", ev_parity_err, 1'b0);
        rk = {$urandom, $urandom};
        model(rk);
        i_key = rk;
        i_decrypt = 1'b0;
        i_key_valid = 1'b1;
        #3;
        i_rst_n = 1'b1;
        step();
        i_key_valid = 1'b0;
        chk("post_rst_valid", o_subkey_valid, 1'b1);
        chk("post_rst_round", o_round, 4'd0);
        drain(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
